// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Sign handling wraps magnitude-only shift-add / restoring-divide iterations.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p, prod_signed;
    logic [WIDTH-1:0]   m, a_q;
    logic               is_div, neg_res, neg_rem, b_zero;
    logic               accept, sgn_op, a_neg, b_neg, take;
    logic [WIDTH-1:0]   mag_a, mag_b, q_fix, r_fix, hi_fix, lo_fix;
    logic [WIDTH:0]     add_sum, rs, diff;

    assign accept = start && (state == IDLE);
    assign busy   = (state != IDLE);
    assign sgn_op = ~op[0];
    assign a_neg  = sgn_op & a[WIDTH-1];
    assign b_neg  = sgn_op & b[WIDTH-1];
    assign mag_a  = a_neg ? -a : a;
    assign mag_b  = b_neg ? -b : b;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept && !op[2]) state_nxt = op[1] ? DIV : MUL;
            MUL, DIV: if (cnt == LAST) state_nxt = FIX;
            FIX:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // p holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
    assign add_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
    assign rs      = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign diff    = rs - {1'b0, m};
    assign take    = (rs >= {1'b0, m});

    assign prod_signed = neg_res ? -p : p;
    assign q_fix       = neg_res ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign r_fix       = neg_rem ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

    always_comb begin
        hi_fix = prod_signed[2*WIDTH-1:WIDTH];
        lo_fix = prod_signed[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                hi_fix = a_q;
                lo_fix = {WIDTH{1'b1}};
            end else begin
                hi_fix = r_fix;
                lo_fix = q_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            cnt     <= '0;
            p       <= '0;
            m       <= '0;
            a_q     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    case (op)
                        3'b100: hi <= a;
                        3'b101: lo <= a;
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            cnt     <= '0;
                            a_q     <= a;
                            is_div  <= op[1];
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            b_zero  <= (b == '0);
                            p       <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                            m       <= op[1] ? mag_b : mag_a;
                        end
                        default: ;
                    endcase
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    p   <= {add_sum, p[WIDTH-1:1]};
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    p   <= take ? {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1}
                                : {rs[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
                end
                FIX: begin
                    hi   <= hi_fix;
                    lo   <= lo_fix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It serves MULT/MULTU/DIV/DIVU/MTHI/MTLO for the datapath and computes one bit per cycle. It exposes a start/busy/done handshake, so the control unit stalls on MFHI/MFLO or a new multiply/divide instead of holding a combinational multiplier. It sits beside the main ALU; HI/LO are readable at any time.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; minimum 4.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on a rising edge where start=1 and busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 accepted as no-op.
- a  input  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO source.
- b  input  WIDTH  operand B: multiplier or divisor.
- busy  output  1  high while a multiply/divide is in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result in that cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

## Operation
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0. Reset mid-operation aborts it; the partial result is discarded.
- States:
  - IDLE
  - MUL: WIDTH shift-add iterations on operand magnitudes.
  - DIV: WIDTH restoring iterations on operand magnitudes.
  - FIX: sign correction, special cases, HI/LO write.
- Transitions:
  - IDLE→MUL on accepted op 000/001.
  - IDLE→DIV on accepted op 010/011.
  - MUL/DIV→FIX after the WIDTH-th iteration.
  - FIX→IDLE always.
- Operand capture: a, b and op are registered at the accept edge. Later input changes have no effect.
- Signed ops: the unit works on |a| and |b|.
  - The product is negated if the signs differ; {hi,lo} = full 2*WIDTH-bit product.
  - The quotient (lo) is negated if the signs differ.
  - The remainder (hi) takes the sign of the dividend.
- Unsigned ops use the raw operands with no correction.
- Divide by zero (b=0, DIV or DIVU): lo = all ones, hi = a as captured. No error flag.
- Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0. This falls out of the magnitude arithmetic and is required.
- MTHI/MTLO: when accepted in IDLE, hi (resp. lo) := a at the accept edge. Single cycle; busy and done stay 0; the other register is unchanged.
- Opcodes 110/111: no register change, no busy, no done.
- Start while busy=1 (any op, including MTHI/MTLO) is ignored with no side effect. Control must hold the request.
- hi/lo keep their old values throughout MUL/DIV/FIX. They change only at the FIX→IDLE edge.

## Timing
- Accept edge E0 (start=1, busy=0, mul/div op): busy=1 from after E0.
- Iteration edges E1..E_WIDTH; the state is FIX after E_WIDTH.
- Edge E_(WIDTH+1): hi/lo loaded, busy=0, done=1 for exactly that one cycle.
- Latency: WIDTH+1 cycles from accept to result visible (33 for WIDTH=32).
- Back-to-back: start may be high in the done cycle (busy=0) and is accepted at the next edge, giving zero idle cycles.
- MTHI/MTLO: new value visible in the cycle after the accept edge.
- rst has priority over start in the same cycle.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 cycles after accept, busy high for the 33 intervening cycles. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1. DIV 7/-2 → lo=0xFFFFFFFD, hi=1.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Idle MTLO a=0x1234 → lo=0x1234 next cycle, hi unchanged, done never pulses. MTHI issued while busy → hi unchanged at done; the multiply result wins.
- rst asserted 10 cycles into a DIV → next cycle busy=0, hi=lo=0, no done. A following MULTU 6×7 → lo=42, hi=0.
- WIDTH=8: MULT 0x80×0x80 → hi=0x40, lo=0x00, latency 9. Back-to-back MULTU issued in the done cycle accepted with no gap.
